clk_div_gen: RTL and testbench



---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_ch.sv | 64 ++++++
 rtl/clk_div_gen.sv | 53 +++++
 tb/tb_clk_div_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int          CNT_W_DEF    = 8;
  localparam logic [15:0] DIV_INIT_DEF = {8'd9, 8'd1};

  // Channel-select width; a single-channel build still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, current/pending divisor,
// enable gating that only stops on a falling output edge, and the tick pulse.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pdiv;

  // wr is only ever granted while pend is low, so a write and an apply of the
  // pending divisor never land on the same edge.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt     <= '0;
      div     <= DIV_RST;
      pdiv    <= '0;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (wr) begin
        pdiv <= wr_div;
        pend <= 1'b1;
      end
      // A disabled channel that is already low is parked; this also covers a
      // disable that arrives during the low phase, which cannot produce a runt.
      if (sync || (!en && !clk_out)) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pend) begin
          div  <= pdiv;
          pend <= 1'b0;
        end
      end else if (cnt == div) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        if (!clk_out) begin
          tick <= 1'b1;
        end else if (pend) begin
          div  <= pdiv;
          pend <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: config decode and ready mux around NUM_CH
// independent divider channels.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int                        NUM_CH   = 2,
  parameter int                        CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = (NUM_CH*CNT_W)'(DIV_INIT_DEF),
  localparam int                       CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;

  // Unmapped channel indices read as ready so a stray write drains harmlessly.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk     (clk),
      .rst_L   (rst_L),
      .en      (ch_en[g]),
      .sync    (sync_req),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen (3 channels): directed scenarios plus random config
// traffic, checked every cycle against a timestamp-based reference model.
module tb_clk_div_gen;

  localparam int          NC   = 3;
  localparam logic [23:0] INIT = {8'd5, 8'd9, 8'd1};

  logic       clk = 1'b0;
  logic       rst_L;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] ch_en;
  logic       sync_req;
  logic [2:0] clk_out;
  logic [2:0] tick;

  clk_div_gen #(.NUM_CH(NC), .CNT_W(8), .DIV_INIT(INIT)) dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ch_en     (ch_en),
    .sync_req  (sync_req),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_edge = 0;

  // Model: each channel remembers its level and the edge number at which the
  // current phase began; the next toggle is due div+1 edges after that.
  bit m_lvl[NC];
  bit m_tick[NC];
  bit m_pv[NC];
  int m_start[NC];
  int m_div[NC];
  int m_pdiv[NC];

  logic [2:0] en_cur;
  bit         acc_last;
  int         first_rise[NC];
  int         last_rise[NC];
  int         prev_rise[NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int div_init(input int i);
    logic [23:0] v;
    v = INIT;
    return int'(v[i*8 +: 8]);
  endfunction

  function automatic bit model_ready(input logic [1:0] c);
    if (int'(c) >= NC) return 1'b1;
    return !m_pv[c];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_lvl[i]   = 1'b0;
      m_tick[i]  = 1'b0;
      m_pv[i]    = 1'b0;
      m_pdiv[i]  = 0;
      m_div[i]   = div_init(i);
      m_start[i] = n_edge;
    end
  endtask

  task automatic model_edge(input logic [2:0] en, input logic s, input logic v,
                            input logic [1:0] c, input logic [7:0] d);
    bit acc;
    acc = v && model_ready(c);
    n_edge++;
    for (int i = 0; i < NC; i++) begin
      m_tick[i] = 1'b0;
      if (s || (!en[i] && !m_lvl[i])) begin
        m_lvl[i]   = 1'b0;
        m_start[i] = n_edge;
        if (m_pv[i]) begin m_div[i] = m_pdiv[i]; m_pv[i] = 1'b0; end
      end else if (n_edge == m_start[i] + m_div[i] + 1) begin
        m_lvl[i]   = !m_lvl[i];
        m_start[i] = n_edge;
        if (m_lvl[i]) m_tick[i] = 1'b1;
        else if (m_pv[i]) begin m_div[i] = m_pdiv[i]; m_pv[i] = 1'b0; end
      end
    end
    if (acc && int'(c) < NC) begin
      m_pdiv[c] = int'(d);
      m_pv[c]   = 1'b1;
    end
  endtask

  task automatic clear_rises();
    for (int i = 0; i < NC; i++) begin
      first_rise[i] = -1; last_rise[i] = -1; prev_rise[i] = -1;
    end
  endtask

  task automatic cyc(input logic [2:0] en, input logic s, input logic v,
                     input logic [1:0] c, input logic [7:0] d);
    logic [2:0] exp_clk, exp_tick;
    ch_en = en; sync_req = s; cfg_valid = v; cfg_ch = c; cfg_div = d;
    #1;
    chk("cfg_ready", cfg_ready, model_ready(c));
    acc_last = v && model_ready(c);
    @(posedge clk);
    model_edge(en, s, v, c, d);
    #1;
    for (int i = 0; i < NC; i++) begin
      exp_clk[i]  = m_lvl[i];
      exp_tick[i] = m_tick[i];
    end
    chk("clk_out", clk_out, exp_clk);
    chk("tick", tick, exp_tick);
    for (int i = 0; i < NC; i++) begin
      if (tick[i]) begin
        if (first_rise[i] < 0) first_rise[i] = n_edge;
        prev_rise[i] = last_rise[i];
        last_rise[i] = n_edge;
      end
    end
  endtask

  task automatic idle();
    cyc(en_cur, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic wait_rise(input int c, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      idle();
      seen = m_tick[c];
    end
    chk(tag, seen, 1'b1);
  endtask

  task automatic write_ch(input logic [1:0] c, input logic [7:0] d, output int stalls);
    stalls   = 0;
    acc_last = 1'b0;
    for (int k = 0; k < 60 && !acc_last; k++) begin
      cyc(en_cur, 1'b0, 1'b1, c, d);
      if (!acc_last) stalls++;
    end
    chk("wr_accept", acc_last, 1'b1);
  endtask

  initial begin
    int   stalls;
    int   e0;
    int   ticks;
    bit   found;
    logic rv, rs;
    logic [1:0] rc;
    logic [7:0] rd;

    rst_L = 1'b0; ch_en = '0; sync_req = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; en_cur = 3'b111;
    clear_rises();
    model_reset();
    #11;
    chk("rst_clk_out", clk_out, 3'b000);
    chk("rst_tick", tick, 3'b000);
    chk("rst_ready", cfg_ready, 1'b1);
    rst_L = 1'b1;

    // Reset divisors: ch0 div 1, ch1 div 9, ch2 div 5.
    repeat (24) idle();
    chk("ch0_first_rise", first_rise[0], 2);
    chk("ch1_first_rise", first_rise[1], 10);
    chk("ch2_first_rise", first_rise[2], 6);
    chk("ch0_period", last_rise[0] - prev_rise[0], 4);

    // New divisor written during the high phase takes effect from the next low phase.
    wait_rise(0, "wait_ch0_rise");
    write_ch(2'd0, 8'd3, stalls);
    write_ch(2'd0, 8'd3, stalls);
    chk("ch0_second_wr_stalled", stalls > 0, 1'b1);
    repeat (24) idle();
    chk("ch0_period_div3", last_rise[0] - prev_rise[0], 8);

    // Disable three cycles into the high phase; the phase must still complete.
    wait_rise(1, "wait_ch1_rise");
    repeat (2) idle();
    en_cur[1] = 1'b0;
    repeat (30) idle();
    chk("ch1_parked_low", clk_out[1], 1'b0);
    en_cur[1] = 1'b1;
    e0 = n_edge + 1;
    wait_rise(1, "wait_ch1_reenable");
    // Rise lands on the tenth edge that sees ch_en high (div 9).
    chk("ch1_reenable_rise", last_rise[1] - e0, 9);

    write_ch(2'd0, 8'd1, stalls);
    repeat (20) idle();

    // Sync while ch0 is high and ch1 is partway through its low phase.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      idle();
      found = m_lvl[0] && !m_lvl[1] && (n_edge - m_start[1] >= 2) && (n_edge - m_start[1] <= 7);
    end
    chk("sync_window_found", found, 1'b1);
    cyc(en_cur, 1'b1, 1'b0, 2'd0, 8'd0);
    chk("sync_all_low", clk_out, 3'b000);
    e0 = n_edge;
    clear_rises();
    repeat (12) idle();
    chk("sync_ch0_rise", first_rise[0] - e0, 2);
    chk("sync_ch1_rise", first_rise[1] - e0, 10);

    // div 0: toggle every edge, tick every other edge.
    write_ch(2'd2, 8'd0, stalls);
    repeat (14) idle();
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (tick[2]) ticks++;
    end
    chk("ch2_div0_ticks", ticks, 4);

    // Channel index 3 does not exist: accepted, no effect.
    cyc(en_cur, 1'b0, 1'b1, 2'd3, 8'd7);
    chk("oor_ready", cfg_ready, 1'b1);
    repeat (12) idle();

    for (int k = 0; k < 400; k++) begin
      rv = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 39) == 0);
      rc = 2'($urandom_range(0, 3));
      rd = 8'($urandom_range(0, 6));
      cyc(en_cur, rs, rv, rc, rd);
    end

    // Asynchronous reset mid-period with a write still pending.
    write_ch(2'd1, 8'd4, stalls);
    cfg_valid = 1'b0;
    cfg_ch    = 2'd1;
    #2;
    rst_L = 1'b0;
    #1;
    chk("async_rst_clk_out", clk_out, 3'b000);
    chk("async_rst_tick", tick, 3'b000);
    chk("async_rst_ready", cfg_ready, 1'b1);
    model_reset();
    #2;
    rst_L = 1'b1;
    e0 = n_edge;
    clear_rises();
    repeat (12) idle();
    chk("post_rst_ch0_rise", first_rise[0] - e0, 2);
    chk("post_rst_ch1_rise", first_rise[1] - e0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
